// File: rtl/sram_word_client_if.sv
// Host-side bundle for sram_word_client: single-word request/ack bus plus the line-fill stream.
// master = cache logic driving requests, slave = the client controller.
interface sram_word_client_if #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 7
);
    localparam int LANE_BITS = $clog2(DATA_WIDTH / 32);

    logic                               i_req;
    logic                               i_we;
    logic [ADDRESS_WIDTH+LANE_BITS-1:0] i_addr;
    logic [3:0]                         i_sel;
    logic [31:0]                        i_wdata;
    logic                               o_ack;
    logic [31:0]                        o_rdata;

    logic                               i_fill_start;
    logic [ADDRESS_WIDTH-1:0]           i_fill_line;
    logic                               i_fill_valid;
    logic [31:0]                        i_fill_data;
    logic                               o_fill_ready;
    logic                               o_fill_done;

    modport master (
        output i_req, i_we, i_addr, i_sel, i_wdata,
        output i_fill_start, i_fill_line, i_fill_valid, i_fill_data,
        input  o_ack, o_rdata, o_fill_ready, o_fill_done
    );

    modport slave (
        input  i_req, i_we, i_addr, i_sel, i_wdata,
        input  i_fill_start, i_fill_line, i_fill_valid, i_fill_data,
        output o_ack, o_rdata, o_fill_ready, o_fill_done
    );
endinterface

// File: rtl/sram_word_client.sv
// 32-bit host client for a byte-enabled line SRAM: lane-mapped word reads/writes with the
// SRAM's 2-cycle read latency absorbed, and 32-bit fill bursts packed into one line write.
module sram_word_client #(
    parameter int DATA_WIDTH    = 128,
    parameter int ADDRESS_WIDTH = 7
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    sram_word_client_if.slave         bus,
    output logic [ADDRESS_WIDTH-1:0]  o_sram_address,
    output logic [DATA_WIDTH-1:0]     o_sram_write_data,
    output logic                      o_sram_write_enable,
    output logic [DATA_WIDTH/8-1:0]   o_sram_byte_enable,
    input  logic [DATA_WIDTH-1:0]     i_sram_read_data
);
    localparam int LANES     = DATA_WIDTH / 32;
    localparam int LANE_BITS = $clog2(LANES);
    localparam int BE_W      = DATA_WIDTH / 8;

    localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(LANES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WR      = 3'd1;
    localparam logic [2:0] S_RD1     = 3'd2;
    localparam logic [2:0] S_RD2     = 3'd3;
    localparam logic [2:0] S_RD3     = 3'd4;
    localparam logic [2:0] S_RDACK   = 3'd5;
    localparam logic [2:0] S_FILL    = 3'd6;
    localparam logic [2:0] S_FILL_WR = 3'd7;

    logic [2:0]               state_q, state_d;
    logic [LANE_BITS-1:0]     cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]    buf_q, buf_d;
    logic [ADDRESS_WIDTH-1:0] fill_line_q, fill_line_d;
    logic [LANE_BITS-1:0]     lane_q, lane_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic                     we_q, we_d;
    logic [BE_W-1:0]          be_q, be_d;
    logic                     ack_q, ack_d;
    logic [31:0]              rdata_q, rdata_d;
    logic                     done_q, done_d;

    logic [LANE_BITS-1:0]     req_lane;
    logic [ADDRESS_WIDTH-1:0] req_line;

    assign req_lane = bus.i_addr[LANE_BITS-1:0];
    assign req_line = bus.i_addr[LANE_BITS +: ADDRESS_WIDTH];

    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        fill_line_d = fill_line_q;
        lane_d      = lane_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        we_d        = 1'b0;
        be_d        = '0;
        ack_d       = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.i_fill_start) begin
                    state_d     = S_FILL;
                    fill_line_d = bus.i_fill_line;
                    cnt_d       = '0;
                end else if (bus.i_req) begin
                    lane_d = req_lane;
                    addr_d = req_line;
                    if (bus.i_we) begin
                        state_d = S_WR;
                        we_d    = 1'b1;
                        ack_d   = 1'b1;
                        be_d    = BE_W'(bus.i_sel) << {req_lane, 2'b00};
                        wdata_d = {LANES{bus.i_wdata}};
                    end else begin
                        state_d = S_RD1;
                    end
                end
            end
            S_WR:    state_d = S_IDLE;
            S_RD1:   state_d = S_RD2;
            S_RD2:   state_d = S_RD3;
            S_RD3: begin
                // SRAM q for the address launched at accept is valid in this cycle only.
                state_d = S_RDACK;
                rdata_d = i_sram_read_data[32*lane_q +: 32];
                ack_d   = 1'b1;
            end
            S_RDACK: state_d = S_IDLE;
            S_FILL: begin
                if (bus.i_fill_valid) begin
                    buf_d[32*cnt_q +: 32] = bus.i_fill_data;
                    cnt_d                 = cnt_q + 1'b1;
                    if (cnt_q == LAST_LANE) begin
                        state_d = S_FILL_WR;
                        we_d    = 1'b1;
                        be_d    = '1;
                        addr_d  = fill_line_q;
                        wdata_d = buf_d;
                        done_d  = 1'b1;
                    end
                end
            end
            S_FILL_WR: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            // NOTE: the line buffer is reset so an aborted fill never leaks stale words.
            buf_q       <= '0;
            fill_line_q <= '0;
            lane_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking only, so every register samples pre-edge values.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            fill_line_q <= fill_line_d;
            lane_q      <= lane_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            be_q        <= be_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
        end
    end

    assign bus.o_ack          = ack_q;
    assign bus.o_rdata        = rdata_q;
    assign bus.o_fill_ready   = (state_q == S_FILL);
    assign bus.o_fill_done    = done_q;
    assign o_sram_address      = addr_q;
    assign o_sram_write_data   = wdata_q;
    assign o_sram_write_enable = we_q;
    assign o_sram_byte_enable  = be_q;
endmodule

// File: tb/tb_sram_word_client.sv
// Directed bench for sram_word_client against a 2-cycle-latency byte-enabled line SRAM model.
module tb_sram_word_client;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [6:0]   sram_addr;
    logic [127:0] sram_wdata;
    logic         sram_we;
    logic [15:0]  sram_be;
    logic [127:0] sram_q = '0;

    int checks = 0;
    int errors = 0;
    int ack_count = 0;
    int done_count = 0;
    int we_count = 0;

    sram_word_client_if bus ();

    sram_word_client dut (
        .i_clk               (clk),
        .i_rst_n             (rst_n),
        .bus                 (bus),
        .o_sram_address      (sram_addr),
        .o_sram_write_data   (sram_wdata),
        .o_sram_write_enable (sram_we),
        .o_sram_byte_enable  (sram_be),
        .i_sram_read_data    (sram_q)
    );

    always #5 clk = ~clk;

    // SRAM model: registered address, registered q, byte-enabled write.
    logic [127:0] mem [128] = '{default: '0};
    logic [6:0]   m_addr_r = '0;

    function automatic logic [127:0] merge(input logic [127:0] old_w, input logic [127:0] new_w,
                                           input logic [15:0] be);
        logic [127:0] r;
        r = old_w;
        for (int b = 0; b < 16; b++)
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (sram_we) mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_be);
        m_addr_r <= sram_addr;
        sram_q   <= mem[m_addr_r];
    end

    always @(negedge clk) begin
        if (bus.o_ack)       ack_count  <= ack_count + 1;
        if (bus.o_fill_done) done_count <= done_count + 1;
        if (sram_we)         we_count   <= we_count + 1;
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " ack"},        128'(bus.o_ack),        '0);
        check({tag, " rdata"},      128'(bus.o_rdata),      '0);
        check({tag, " fill_ready"}, 128'(bus.o_fill_ready), '0);
        check({tag, " fill_done"},  128'(bus.o_fill_done),  '0);
        check({tag, " sram_addr"},  128'(sram_addr),        '0);
        check({tag, " sram_wdata"}, sram_wdata,             '0);
        check({tag, " sram_we"},    128'(sram_we),          '0);
        check({tag, " sram_be"},    128'(sram_be),          '0);
    endtask

    // Called just after a negedge; presents a request and waits (bounded) for its ack.
    task automatic do_req(input logic we, input logic [8:0] addr, input logic [3:0] sel,
                          input logic [31:0] wdata, input bit hold, output int lat,
                          output logic [6:0] s_addr, output logic [15:0] s_be,
                          output logic s_we, output logic [127:0] s_wdata,
                          output logic [31:0] rdata);
        bus.i_req   = 1'b1;
        bus.i_we    = we;
        bus.i_addr  = addr;
        bus.i_sel   = sel;
        bus.i_wdata = wdata;
        lat = -1;
        s_addr = '0; s_be = '0; s_we = 1'b0; s_wdata = '0; rdata = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (bus.o_ack) begin
                lat = k; s_addr = sram_addr; s_be = sram_be; s_we = sram_we;
                s_wdata = sram_wdata; rdata = bus.o_rdata;
                break;
            end
        end
        if (!hold) begin
            bus.i_req = 1'b0;
            @(negedge clk);
        end
    endtask

    // Called one cycle after fill_start was sampled; feeds a line, optional gap before word `gap`.
    task automatic feed_words(input string tag, input logic [6:0] line, input logic [127:0] data,
                              input int gap);
        int  we_before;
        bit  found;
        we_before = we_count;
        check({tag, " ready"}, 128'(bus.o_fill_ready), 128'(1));
        for (int i = 0; i < 4; i++) begin
            if (i == gap) begin
                bus.i_fill_valid = 1'b0;
                @(negedge clk);
            end
            bus.i_fill_valid = 1'b1;
            bus.i_fill_data  = data[32*i +: 32];
            @(negedge clk);
        end
        bus.i_fill_valid = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (bus.o_fill_done) begin
                found = 1'b1;
                check({tag, " we"},   128'(sram_we),   128'(1));
                check({tag, " be"},   128'(sram_be),   128'(16'hFFFF));
                check({tag, " addr"}, 128'(sram_addr), 128'(line));
                check({tag, " data"}, sram_wdata,      data);
                break;
            end
            @(negedge clk);
        end
        check({tag, " done seen"}, 128'(found), 128'(1));
        @(negedge clk);
        #1;
        check({tag, " one write"}, 128'(we_count - we_before), 128'(1));
        check({tag, " ready low"}, 128'(bus.o_fill_ready), '0);
    endtask

    typedef struct {
        logic        we;
        logic [8:0]  addr;
        logic [3:0]  sel;
        logic [31:0] wdata;
        int          lat;
        logic [6:0]  e_addr;
        logic [15:0] e_be;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int           lat;
        logic [6:0]   s_addr;
        logic [15:0]  s_be;
        logic         s_we;
        logic [127:0] s_wdata;
        logic [31:0]  rdata;
        int           acks_before, done_before;

        vecs[0] = '{1'b1, 9'h005, 4'b0011, 32'hDEADBEEF, 1, 7'd1,   16'h0030, 32'h0};
        vecs[1] = '{1'b0, 9'h005, 4'b0000, 32'h0,        4, 7'd1,   16'h0000, 32'h0000BEEF};
        vecs[2] = '{1'b1, 9'h1FF, 4'b1111, 32'hCAFEF00D, 1, 7'd127, 16'hF000, 32'h0};
        vecs[3] = '{1'b0, 9'h1FF, 4'b0000, 32'h0,        4, 7'd127, 16'h0000, 32'hCAFEF00D};
        vecs[4] = '{1'b1, 9'h010, 4'b0000, 32'hFFFFFFFF, 1, 7'd4,   16'h0000, 32'h0};
        vecs[5] = '{1'b0, 9'h010, 4'b0000, 32'h0,        4, 7'd4,   16'h0000, 32'h0};
        vecs[6] = '{1'b1, 9'h012, 4'b1010, 32'h12345678, 1, 7'd4,   16'h0A00, 32'h0};
        vecs[7] = '{1'b0, 9'h012, 4'b0000, 32'h0,        4, 7'd4,   16'h0000, 32'h12005600};

        bus.i_req = 1'b0; bus.i_we = 1'b0; bus.i_addr = '0; bus.i_sel = '0; bus.i_wdata = '0;
        bus.i_fill_start = 1'b0; bus.i_fill_line = '0; bus.i_fill_valid = 1'b0;
        bus.i_fill_data = '0;

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            acks_before = ack_count;
            do_req(vecs[i].we, vecs[i].addr, vecs[i].sel, vecs[i].wdata, 1'b0,
                   lat, s_addr, s_be, s_we, s_wdata, rdata);
            check($sformatf("v%0d latency", i), 128'(lat),    128'(vecs[i].lat));
            check($sformatf("v%0d addr", i),    128'(s_addr), 128'(vecs[i].e_addr));
            check($sformatf("v%0d we", i),      128'(s_we),   128'(vecs[i].we));
            check($sformatf("v%0d be", i),      128'(s_be),   128'(vecs[i].e_be));
            if (vecs[i].we)
                check($sformatf("v%0d wdata", i), s_wdata, {4{vecs[i].wdata}});
            else
                check($sformatf("v%0d rdata", i), 128'(rdata), 128'(vecs[i].e_rdata));
            #1;
            check($sformatf("v%0d one ack", i), 128'(ack_count - acks_before), 128'(1));
        end

        // Fill line 7 with an idle gap before word 2, then read one lane back.
        bus.i_fill_start = 1'b1; bus.i_fill_line = 7'd7;
        @(negedge clk);
        bus.i_fill_start = 1'b0;
        feed_words("fill7", 7'd7, 128'h44444444_33333333_22222222_11111111, 2);
        do_req(1'b0, {7'd7, 2'd3}, 4'b0, 32'h0, 1'b0, lat, s_addr, s_be, s_we, s_wdata, rdata);
        check("fill7 readback", 128'(rdata), 128'(32'h44444444));

        // Fill start and read request in the same IDLE cycle: fill first, read still served.
        acks_before = ack_count;
        done_before = done_count;
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = {7'd9, 2'd1};
        bus.i_fill_start = 1'b1; bus.i_fill_line = 7'd9;
        @(negedge clk);
        bus.i_fill_start = 1'b0;
        feed_words("fill9", 7'd9, 128'hA0000003_A0000002_A0000001_A0000000, -1);
        check("fill9 no early ack", 128'(ack_count - acks_before), '0);
        check("fill9 one done", 128'(done_count - done_before), 128'(1));
        do_req(1'b0, {7'd9, 2'd1}, 4'b0, 32'h0, 1'b0, lat, s_addr, s_be, s_we, s_wdata, rdata);
        check("pending read latency", 128'(lat), 128'(4));
        check("pending read rdata", 128'(rdata), 128'(32'hA0000001));
        #1;
        check("pending read one ack", 128'(ack_count - acks_before), 128'(1));

        // Back-to-back: next request presented in the ack cycle of the previous one.
        @(negedge clk);
        acks_before = ack_count;
        do_req(1'b1, 9'h1FE, 4'b1100, 32'hAABBCCDD, 1'b1, lat, s_addr, s_be, s_we, s_wdata, rdata);
        check("b2b wr latency", 128'(lat), 128'(1));
        check("b2b wr be", 128'(s_be), 128'(16'h0C00));
        do_req(1'b0, 9'h1FE, 4'b0, 32'h0, 1'b1, lat, s_addr, s_be, s_we, s_wdata, rdata);
        check("b2b rd1 latency", 128'(lat), 128'(5));
        check("b2b rd1 rdata", 128'(rdata), 128'(32'hAABB0000));
        do_req(1'b0, 9'h1FF, 4'b0, 32'h0, 1'b0, lat, s_addr, s_be, s_we, s_wdata, rdata);
        check("b2b rd2 latency", 128'(lat), 128'(5));
        check("b2b rd2 rdata", 128'(rdata), 128'(32'hCAFEF00D));
        repeat (6) @(negedge clk);
        #1;
        check("b2b ack count", 128'(ack_count - acks_before), 128'(3));

        // Reset during RD2 of a read.
        @(negedge clk);
        acks_before = ack_count;
        bus.i_req = 1'b1; bus.i_we = 1'b0; bus.i_addr = 9'h1FF;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        bus.i_req = 1'b0;
        #1;
        check_zero("rst in RD2");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        check("rst in RD2 no ack", 128'(ack_count - acks_before), '0);

        // Reset during FILL after two words; the next fill must start from word 0.
        @(negedge clk);
        done_before = done_count;
        bus.i_fill_start = 1'b1; bus.i_fill_line = 7'd3;
        @(negedge clk);
        bus.i_fill_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bus.i_fill_valid = 1'b1;
            bus.i_fill_data  = 32'hBAD00000 + i;
            @(negedge clk);
        end
        rst_n = 1'b0;
        bus.i_fill_valid = 1'b0;
        #1;
        check_zero("rst in FILL");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        check("rst in FILL no done", 128'(done_count - done_before), '0);
        @(negedge clk);
        bus.i_fill_start = 1'b1; bus.i_fill_line = 7'd3;
        @(negedge clk);
        bus.i_fill_start = 1'b0;
        feed_words("fill3", 7'd3, 128'h0D0D0D0D_0C0C0C0C_0B0B0B0B_0A0A0A0A, -1);
        do_req(1'b1, 9'h00C, 4'b0001, 32'h000000EE, 1'b0, lat, s_addr, s_be, s_we, s_wdata, rdata);
        check("post-rst wr latency", 128'(lat), 128'(1));
        check("post-rst wr be", 128'(s_be), 128'(16'h0001));
        do_req(1'b0, 9'h00C, 4'b0, 32'h0, 1'b0, lat, s_addr, s_be, s_we, s_wdata, rdata);
        check("post-rst rd rdata", 128'(rdata), 128'(32'h0A0A0AEE));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
